// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transaction controller in front of SpiMaster; owns CS framing.
// Optional SPI_XFER_FILL_EN: a TX stall in LOAD sends filler 8'hFF instead of waiting.
module spi_xfer_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = $clog2(MAX_LEN),
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iCmdValid,
    output logic             oCmdReady,
    input  logic [LEN_W-1:0] iCmdLen,
    input  logic             iTxValid,
    input  logic [7:0]       iTxData,
    output logic             oTxReady,
    output logic             oRxValid,
    output logic [7:0]       oRxData,
    output logic             oBusy,
    output logic             oDone,
    output logic [7:0]       oMstDin,
    output logic             oMstStart,
    input  logic [7:0]       iMstDout,
    input  logic             iMstReady,
    output logic             oSpiCs
);

    localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_W  = $clog2(CS_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        XFER,
        HOLD
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] lenQ;
    logic [LEN_W-1:0] byteCnt;
    logic [CNT_W-1:0] csCnt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            lenQ      <= '0;
            byteCnt   <= '0;
            csCnt     <= '0;
            oSpiCs    <= 1'b1;
            oCmdReady <= 1'b1;
            oTxReady  <= 1'b0;
            oRxValid  <= 1'b0;
            oRxData   <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oMstDin   <= '0;
            oMstStart <= 1'b0;
        end else begin
            oMstStart <= 1'b0;
            oRxValid  <= 1'b0;
            oDone     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iCmdValid) begin
                        lenQ      <= iCmdLen;
                        byteCnt   <= '0;
                        csCnt     <= '0;
                        oSpiCs    <= 1'b0;
                        oCmdReady <= 1'b0;
                        oBusy     <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (csCnt == SETUP_LAST) begin
                        csCnt    <= '0;
                        oTxReady <= 1'b1;
                        state    <= LOAD;
                    end else begin
                        csCnt <= csCnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (iTxValid) begin
                        oMstDin   <= iTxData;
                        oMstStart <= 1'b1;
                        oTxReady  <= 1'b0;
                        state     <= XFER;
                    end
`ifdef SPI_XFER_FILL_EN
                    // filler keeps SCLK running; TX stream is not consumed
                    else begin
                        oMstDin   <= 8'hFF;
                        oMstStart <= 1'b1;
                        oTxReady  <= 1'b0;
                        state     <= XFER;
                    end
`endif
                end
                XFER: begin
                    if (iMstReady) begin
                        oRxData  <= iMstDout;
                        oRxValid <= 1'b1;
                        if (byteCnt == lenQ) begin
                            csCnt <= '0;
                            state <= HOLD;
                        end else begin
                            byteCnt  <= byteCnt + 1'b1;
                            oTxReady <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (csCnt == HOLD_LAST) begin
                        oSpiCs    <= 1'b1;
                        oDone     <= 1'b1;
                        oCmdReady <= 1'b1;
                        oBusy     <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        csCnt <= csCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural SpiMaster model and
// scoreboard queues for master bytes and received bytes.
module tb_spi_xfer_ctrl;

    localparam int LEN_W    = 4;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;

    logic             iClk = 1'b0;
    logic             iRst = 1'b1;
    logic             iCmdValid = 1'b0;
    logic             oCmdReady;
    logic [LEN_W-1:0] iCmdLen = '0;
    logic             iTxValid = 1'b0;
    logic [7:0]       iTxData = '0;
    logic             oTxReady;
    logic             oRxValid;
    logic [7:0]       oRxData;
    logic             oBusy;
    logic             oDone;
    logic [7:0]       oMstDin;
    logic             oMstStart;
    logic [7:0]       iMstDout = '0;
    logic             iMstReady = 1'b0;
    logic             oSpiCs;

    spi_xfer_ctrl #(
        .MAX_LEN (16),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iCmdValid(iCmdValid),
        .oCmdReady(oCmdReady),
        .iCmdLen  (iCmdLen),
        .iTxValid (iTxValid),
        .iTxData  (iTxData),
        .oTxReady (oTxReady),
        .oRxValid (oRxValid),
        .oRxData  (oRxData),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oMstDin  (oMstDin),
        .oMstStart(oMstStart),
        .iMstDout (iMstDout),
        .iMstReady(iMstReady),
        .oSpiCs   (oSpiCs)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    logic [7:0] dinQ[$];
    logic [7:0] rxQ[$];
    int errors = 0;
    int checks = 0;
    int startCnt = 0;
    int doneCnt = 0;
    int csErr = 0;
    int readyCyc = 0;
    bit haveReady = 0;
    bit gapChk = 0;
    bit csWatch = 0;
    bit mstFixed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SpiMaster model: answers 2 cycles after each start unless reset intervenes
    initial begin
        logic [7:0] d;
        bit aborted;
        forever begin
            @(negedge iClk);
            if (oMstStart && !iRst) begin
                d = oMstDin;
                aborted = 0;
                repeat (2) begin
                    @(negedge iClk);
                    if (iRst) aborted = 1;
                end
                if (!aborted) begin
                    iMstReady = 1'b1;
                    iMstDout  = mstFixed ? 8'h3C : ~d;
                    readyCyc  = cyc;
                    haveReady = 1;
                    @(negedge iClk);
                    iMstReady = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge iClk);
            if (oMstStart) begin
                startCnt++;
                if (dinQ.size() == 0) chk("din_extra", 1, 0);
                else chk("mst_din", oMstDin, dinQ.pop_front());
                if (gapChk && haveReady) chk("mst_gap", cyc - readyCyc, 2);
                haveReady = 0;
            end
            if (oRxValid) begin
                if (rxQ.size() == 0) chk("rx_extra", 1, 0);
                else chk("rx_data", oRxData, rxQ.pop_front());
            end
            if (oDone) doneCnt++;
            if (csWatch && oSpiCs && !oDone) csErr++;
        end
    end

    task automatic checkReset();
        chk("rst_cs", oSpiCs, 1);
        chk("rst_cmdrdy", oCmdReady, 1);
        chk("rst_txrdy", oTxReady, 0);
        chk("rst_rxvalid", oRxValid, 0);
        chk("rst_rxdata", oRxData, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_din", oMstDin, 0);
        chk("rst_start", oMstStart, 0);
    endtask

    task automatic sendCmd(input logic [LEN_W-1:0] len);
        int n = 0;
        chk("cmd_ready_idle", oCmdReady, 1);
        iCmdLen   = len;
        iCmdValid = 1'b1;
        @(negedge iClk);
        iCmdValid = 1'b0;
        chk("cs_low_n1", oSpiCs, 0);
        chk("busy_n1", oBusy, 1);
        while (!oTxReady && n < 100) begin
            @(negedge iClk);
            n++;
        end
        chk("setup_lat", n, CS_SETUP);
    endtask

    task automatic sendByte(input logic [7:0] d);
        int n = 0;
        dinQ.push_back(d);
        rxQ.push_back(mstFixed ? 8'h3C : ~d);
        iTxData  = d;
        iTxValid = 1'b1;
        while (!oTxReady && n < 200) begin
            @(negedge iClk);
            n++;
        end
        chk("tx_accept", oTxReady, 1);
        @(negedge iClk);
        iTxValid = 1'b0;
    endtask

    task automatic waitDone(input int s0, input int nBytes);
        int n = 0;
        while (!oDone && n < 500) begin
            @(negedge iClk);
            n++;
        end
        chk("done_seen", oDone, 1);
        chk("done_lat", cyc - readyCyc, CS_HOLD + 1);
        chk("cs_rise", oSpiCs, 1);
        chk("cmd_rdy_done", oCmdReady, 1);
        chk("start_count", startCnt - s0, nBytes);
        chk("rx_drained", rxQ.size(), 0);
        chk("cs_mid_xfer", csErr, 0);
        csWatch = 0;
        @(negedge iClk);
        chk("done_pulse", oDone, 0);
    endtask

    initial begin
        int s0;
        int d0;
        int n;

        @(negedge iClk);
        checkReset();
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);

        // single byte
        mstFixed = 1;
        s0 = startCnt;
        sendCmd(0);
        csWatch = 1;
        sendByte(8'hA5);
        waitDone(s0, 1);

        // 4-byte burst with a command presented mid-transfer
        mstFixed  = 0;
        haveReady = 0;
        gapChk    = 1;
        s0 = startCnt;
        sendCmd(3);
        csWatch = 1;
        sendByte(8'h01);
        iCmdLen   = 0;
        iCmdValid = 1'b1;
        chk("busy_cmd_rdy", oCmdReady, 0);
        @(negedge iClk);
        iCmdValid = 1'b0;
        sendByte(8'h02);
        sendByte(8'h03);
        sendByte(8'h04);
        waitDone(s0, 4);
        gapChk = 0;
        repeat (3) @(negedge iClk);
        chk("cmd_not_queued", oBusy, 0);
        chk("cs_idle", oSpiCs, 1);

        // TX stall after byte 2
        s0 = startCnt;
        sendCmd(3);
        csWatch = 1;
        sendByte(8'h11);
        sendByte(8'h22);
`ifndef SPI_XFER_FILL_EN
        @(negedge iClk);
        d0 = startCnt;
        repeat (19) @(negedge iClk);
        chk("stall_no_start", startCnt - d0, 0);
        chk("stall_txrdy", oTxReady, 1);
        chk("stall_cs", oSpiCs, 0);
        sendByte(8'h33);
`else
        dinQ.push_back(8'hFF);
        rxQ.push_back(8'h00);
        n = 0;
        while (startCnt - s0 < 3 && n < 50) begin
            @(negedge iClk);
            n++;
        end
        chk("fill_start", startCnt - s0, 3);
`endif
        sendByte(8'h44);
        waitDone(s0, 4);

        // reset in XFER of byte 2
        s0 = startCnt;
        sendCmd(3);
        sendByte(8'h55);
        sendByte(8'h66);
        d0 = doneCnt;
        iRst = 1'b1;
        #1;
        checkReset();
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        dinQ.delete();
        rxQ.delete();
        repeat (10) @(negedge iClk);
        chk("rst_no_done", doneCnt - d0, 0);
        chk("rst_cs_idle", oSpiCs, 1);
        chk("rst_busy_idle", oBusy, 0);

        // normal single byte after reset
        mstFixed = 1;
        s0 = startCnt;
        sendCmd(0);
        csWatch = 1;
        sendByte(8'h5A);
        waitDone(s0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
